// File: rtl/key_pkg.sv
// Shared keypad definitions: one-hot key constants, digit type, keypad FSM states.
// Pure definitions, no logic and no latency.
// Imported by key_entry and by the downstream guess comparator.
package key_pkg;

    // One-hot keypad lines: bits0..8 = digits 1..9, bit9 = '*', bit10 = digit 0, bit11 = '#'
    localparam logic [11:0] KEY_1    = 12'h001;
    localparam logic [11:0] KEY_2    = 12'h002;
    localparam logic [11:0] KEY_3    = 12'h004;
    localparam logic [11:0] KEY_4    = 12'h008;
    localparam logic [11:0] KEY_5    = 12'h010;
    localparam logic [11:0] KEY_6    = 12'h020;
    localparam logic [11:0] KEY_7    = 12'h040;
    localparam logic [11:0] KEY_8    = 12'h080;
    localparam logic [11:0] KEY_9    = 12'h100;
    localparam logic [11:0] KEY_STAR = 12'h200;
    localparam logic [11:0] KEY_0    = 12'h400;
    localparam logic [11:0] KEY_HASH = 12'h800;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        K_IDLE,
        K_DEB,
        K_PRESS,
        K_REL
    } kstate_t;

    // More than one key line set at once
    function automatic logic is_multi(input logic [11:0] p);
        return (p & (p - 12'd1)) != 12'd0;
    endfunction

    // Exactly one line set and it is a digit (not '*' or '#')
    function automatic logic is_digit(input logic [11:0] p);
        return !is_multi(p) && ((p & ~(KEY_STAR | KEY_HASH)) != 12'd0);
    endfunction

    // One-hot digit pattern to 0..9; KEY_0 falls through to 0
    function automatic digit_t key_to_digit(input logic [11:0] p);
        digit_t d;
        d = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (p[i]) d = digit_t'(i + 1);
        end
        return d;
    endfunction

endpackage

// File: rtl/key_entry_debounce.sv
// Single-line debouncer: 2-flop synchronizer, stability counter, one-cycle falling-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES samples before the stable level moves; fall is registered.
// No backpressure: the pulse is a fire-and-forget event.
module debounce_1b #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer; resets to the idle level so no edge appears on release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= RESET_VAL;
            sync_2 <= RESET_VAL;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
        end
    end

    // Level follows the synced input only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= RESET_VAL;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync_2;
                    cnt   <= '0;
                    fall  <= ~sync_2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/key_entry.sv
// Keypad entry: debounces keypad + confirm button, stores one digit, offers it as a guess.
// Latency: stable key to key_held = 2 + DEBOUNCE_CYCLES + 1 cycles; confirm to guess_valid = 1 cycle.
// Backpressure: guess held until guess_ready; confirms while a guess is pending are dropped.
// ENTER_KEY_EN: when defined, an accepted lone '#' also acts as a confirm.
module key_entry
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] key,
    input  logic        push_0,
    output logic [11:0] key_save,
    output logic [3:0]  key_num,
    output logic        key_held,
    output logic        multi_key,
    output logic        guess_valid,
    output logic [3:0]  guess,
    input  logic        guess_ready
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [11:0]      key_sync_1;
    logic [11:0]      key_sync;
    kstate_t          state;
    kstate_t          state_next;
    logic [11:0]      cand;
    logic [11:0]      cand_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             key_accept;
    logic             rel_done;
    logic             push_fall;
    logic             confirm;
    logic             hs_done;

    // Two-flop synchronizer on the raw keypad lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_sync_1 <= '0;
            key_sync   <= '0;
        end else begin
            key_sync_1 <= key;
            key_sync   <= key_sync_1;
        end
    end

    // Keypad FSM state, candidate pattern and shared debounce counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= K_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
        end
    end

    // Whole-pattern debounce: a pattern is accepted only if it stays identical; release needs a stable zero run
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        key_accept = 1'b0;
        rel_done   = 1'b0;
        case (state)
            K_IDLE: begin
                if (key_sync != 12'd0) begin
                    state_next = K_DEB;
                    cand_next  = key_sync;
                    cnt_next   = '0;
                end
            end
            K_DEB: begin
                if (key_sync == cand) begin
                    if (cnt == CNT_MAX) begin
                        key_accept = 1'b1;
                        state_next = K_PRESS;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    state_next = K_IDLE;
                    cnt_next   = '0;
                end
            end
            K_PRESS: begin
                // The zero sample that leaves PRESS counts as the first of the release run
                if (key_sync == 12'd0) begin
                    state_next = K_REL;
                    cnt_next   = CNT_W'(1);
                end
            end
            K_REL: begin
                if (key_sync != 12'd0) begin
                    state_next = K_PRESS;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    rel_done   = 1'b1;
                    state_next = K_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = K_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    debounce_1b #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1)
    ) u_push_deb (
        .clk   (clk),
        .reset (reset),
        .din   (push_0),
        .fall  (push_fall)
    );

`ifdef ENTER_KEY_EN
    // '#' and push_0 merge into one event, so a coincident pair yields a single guess
    assign confirm = push_fall | (key_accept & (cand == KEY_HASH));
`else
    assign confirm = push_fall;
`endif

    assign hs_done = guess_valid & guess_ready;

    // Stored digit and multi-key flag; a new digit wins over the post-handshake clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_save  <= '0;
            key_num   <= '0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            if (key_accept && is_multi(cand)) begin
                multi_key <= 1'b1;
            end else if (rel_done) begin
                multi_key <= 1'b0;
            end

            if (key_accept && is_digit(cand)) begin
                key_save <= cand;
                key_num  <= key_to_digit(cand);
                key_held <= 1'b1;
            end else if ((key_accept && (cand == KEY_STAR)) || hs_done) begin
                key_save <= '0;
                key_num  <= '0;
                key_held <= 1'b0;
            end
        end
    end

    // Guess handshake; uses the digit stored before any same-cycle acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guess_valid <= 1'b0;
            guess       <= '0;
        end else if (hs_done) begin
            guess_valid <= 1'b0;
        end else if (confirm && key_held && !guess_valid) begin
            guess_valid <= 1'b1;
            guess       <= key_num;
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry with DEBOUNCE_CYCLES=4; guesses are scoreboarded against expected digits.
module tb_key_entry;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] key;
    logic        push_0;
    logic        guess_ready;
    logic [11:0] key_save;
    logic [3:0]  key_num;
    logic        key_held;
    logic        multi_key;
    logic        guess_valid;
    logic [3:0]  guess;

    int checks = 0;
    int passed = 0;
    int vld_cycles = 0;
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];

    key_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .reset       (reset),
        .key         (key),
        .push_0      (push_0),
        .key_save    (key_save),
        .key_num     (key_num),
        .key_held    (key_held),
        .multi_key   (multi_key),
        .guess_valid (guess_valid),
        .guess       (guess),
        .guess_ready (guess_ready)
    );

    always #5 clk = ~clk;

    // Handshake monitor: records every accepted guess and counts valid cycles
    always @(negedge clk) begin
        if (!reset && guess_valid) begin
            vld_cycles++;
            if (guess_ready) got_q.push_back(guess);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [11:0] p, input int hold);
        key = p;
        step(hold);
        key = 12'd0;
        step(10);
    endtask

    task automatic press_push(input int low);
        push_0 = 1'b0;
        step(low);
        push_0 = 1'b1;
        step(10);
    endtask

    task automatic test_reset;
        reset = 1'b1; key = 12'd0; push_0 = 1'b1; guess_ready = 1'b0;
        step(3);
        checks++;
        if ({key_save, key_num, key_held, multi_key, guess_valid, guess} !== 22'd0)
            $display("FAIL reset_outputs got %h required 0", {key_save, key_num, key_held, multi_key, guess_valid, guess});
        else passed++;
        reset = 1'b0;
        step(3);
        checks++;
        if ({key_held, guess_valid} !== 2'b00) $display("FAIL reset_release got %b required 00", {key_held, guess_valid});
        else passed++;
    endtask

    task automatic test_digit;
        int v0;
        logic [3:0] g, e;
        guess_ready = 1'b1;
        key = 12'h010;
        step(6);
        checks++;
        if (key_held !== 1'b0) $display("FAIL latency_early key_held=%b required 0", key_held); else passed++;
        step(1);
        checks++;
        if (key_held !== 1'b1) $display("FAIL latency_exact key_held=%b required 1", key_held); else passed++;
        checks++;
        if (key_num !== 4'd5) $display("FAIL digit_num key_num=%0d required 5", key_num); else passed++;
        checks++;
        if (key_save !== 12'h010) $display("FAIL digit_save key_save=%h required 010", key_save); else passed++;
        step(3);
        key = 12'd0;
        step(10);
        v0 = vld_cycles;
        exp_q.push_back(4'd5);
        press_push(10);
        for (int i = 0; i < 50 && got_q.size() == 0; i++) step(1);
        checks++;
        if (got_q.size() == 0) $display("FAIL digit_sb got no guess required %0d", exp_q[0]);
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) $display("FAIL digit_sb guess=%0d required %0d", g, e); else passed++;
        end
        checks++;
        if (vld_cycles - v0 !== 1) $display("FAIL digit_pulse valid cycles=%0d required 1", vld_cycles - v0); else passed++;
        checks++;
        if ({key_held, key_save} !== 13'd0) $display("FAIL digit_cleared held/save=%h required 0", {key_held, key_save}); else passed++;
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 6; i++) begin
            key = 12'h400; step(1);
            key = 12'd0;   step(1);
        end
        step(4);
        checks++;
        if (key_held !== 1'b0) $display("FAIL bounce_reject key_held=%b required 0", key_held); else passed++;
        key = 12'h400;
        step(8);
        checks++;
        if (key_save !== 12'h400) $display("FAIL bounce_save key_save=%h required 400", key_save); else passed++;
        checks++;
        if ({key_held, key_num} !== 5'b1_0000) $display("FAIL bounce_num held/num=%b required 10000", {key_held, key_num}); else passed++;
        key = 12'd0;
        step(10);
    endtask

    task automatic test_multi;
        press_key(12'h200, 10);
        checks++;
        if ({key_held, key_save} !== 13'd0) $display("FAIL star_clear held/save=%h required 0", {key_held, key_save}); else passed++;
        key = 12'h003;
        step(10);
        checks++;
        if (multi_key !== 1'b1) $display("FAIL multi_set multi_key=%b required 1", multi_key); else passed++;
        checks++;
        if (key_held !== 1'b0) $display("FAIL multi_held key_held=%b required 0", key_held); else passed++;
        key = 12'd0;
        step(10);
        checks++;
        if (multi_key !== 1'b0) $display("FAIL multi_release multi_key=%b required 0", multi_key); else passed++;
    endtask

    task automatic test_backpressure;
        int bad;
        logic [3:0] g, e;
        guess_ready = 1'b0;
        press_key(12'h040, 10);
        exp_q.push_back(4'd7);
        press_push(10);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(guess_valid === 1'b1 && guess === 4'd7)) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) $display("FAIL bp_hold bad cycles=%0d required 0", bad); else passed++;
        press_push(10);
        press_key(12'h004, 10);
        checks++;
        if (key_num !== 4'd3) $display("FAIL bp_new_digit key_num=%0d required 3", key_num); else passed++;
        checks++;
        if ({guess_valid, guess} !== 5'b1_0111) $display("FAIL bp_guess_kept valid/guess=%b required 10111", {guess_valid, guess}); else passed++;
        checks++;
        if (got_q.size() != 0) $display("FAIL bp_no_early_hs handshakes=%0d required 0", got_q.size()); else passed++;
        guess_ready = 1'b1;
        for (int i = 0; i < 50 && got_q.size() == 0; i++) step(1);
        step(5);
        checks++;
        if (got_q.size() != 1) $display("FAIL bp_sb handshakes=%0d required 1", got_q.size());
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) $display("FAIL bp_sb guess=%0d required %0d", g, e); else passed++;
        end
        checks++;
        if (key_held !== 1'b0) $display("FAIL bp_cleared key_held=%b required 0", key_held); else passed++;
    endtask

    task automatic test_star;
        int v0;
        guess_ready = 1'b1;
        press_key(12'h004, 10);
        checks++;
        if (key_held !== 1'b1) $display("FAIL star_store key_held=%b required 1", key_held); else passed++;
        press_key(12'h200, 10);
        checks++;
        if (key_held !== 1'b0) $display("FAIL star_held key_held=%b required 0", key_held); else passed++;
        v0 = vld_cycles;
        press_push(10);
        checks++;
        if (vld_cycles != v0 || got_q.size() != 0) $display("FAIL star_no_guess valid cycles=%0d required 0", vld_cycles - v0); else passed++;
    endtask

    task automatic test_same_cycle;
        int v0;
        logic [3:0] g, e;
        guess_ready = 1'b0;
        press_key(12'h008, 10);
        key = 12'h020; push_0 = 1'b0;
        step(10);
        key = 12'd0; push_0 = 1'b1;
        step(10);
        checks++;
        if ({guess_valid, guess} !== 5'b1_0100) $display("FAIL same_guess valid/guess=%b required 10100", {guess_valid, guess}); else passed++;
        checks++;
        if (key_num !== 4'd6) $display("FAIL same_num key_num=%0d required 6", key_num); else passed++;
        exp_q.push_back(4'd4);
        guess_ready = 1'b1;
        for (int i = 0; i < 50 && got_q.size() == 0; i++) step(1);
        checks++;
        if (got_q.size() == 0) $display("FAIL same_sb got no guess required %0d", exp_q[0]);
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) $display("FAIL same_sb guess=%0d required %0d", g, e); else passed++;
        end
        step(3);
        v0 = vld_cycles;
        key = 12'h020; push_0 = 1'b0;
        step(10);
        key = 12'd0; push_0 = 1'b1;
        step(10);
        checks++;
        if (vld_cycles != v0 || key_held !== 1'b1) $display("FAIL same_empty valid cycles=%0d held=%b required 0/1", vld_cycles - v0, key_held); else passed++;
    endtask

    task automatic test_reset_mid;
        guess_ready = 1'b0;
        press_key(12'h100, 10);
        press_push(10);
        checks++;
        if ({guess_valid, guess} !== 5'b1_1001) $display("FAIL rst_pre valid/guess=%b required 11001", {guess_valid, guess}); else passed++;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({key_save, key_num, key_held, multi_key, guess_valid, guess} !== 22'd0)
            $display("FAIL rst_async outputs=%h required 0", {key_save, key_num, key_held, multi_key, guess_valid, guess});
        else passed++;
        step(2);
        reset = 1'b0;
        step(3);
        checks++;
        if (got_q.size() != 0 || exp_q.size() != 0) $display("FAIL rst_sb got=%0d pending=%0d required 0/0", got_q.size(), exp_q.size()); else passed++;
    endtask

    task automatic test_hash;
`ifdef ENTER_KEY_EN
        logic [3:0] g, e;
        guess_ready = 1'b0;
        press_key(12'h002, 10);
        press_key(12'h800, 10);
        checks++;
        if ({guess_valid, guess} !== 5'b1_0010) $display("FAIL hash_guess valid/guess=%b required 10010", {guess_valid, guess}); else passed++;
        exp_q.push_back(4'd2);
        guess_ready = 1'b1;
        for (int i = 0; i < 50 && got_q.size() == 0; i++) step(1);
        checks++;
        if (got_q.size() == 0) $display("FAIL hash_sb got no guess required %0d", exp_q[0]);
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) $display("FAIL hash_sb guess=%0d required %0d", g, e); else passed++;
        end
        press_key(12'h010, 10);
        exp_q.push_back(4'd5);
        key = 12'h800; push_0 = 1'b0;
        step(10);
        key = 12'd0; push_0 = 1'b1;
        step(15);
        checks++;
        if (got_q.size() != 1) $display("FAIL hash_both handshakes=%0d required 1", got_q.size());
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) $display("FAIL hash_both guess=%0d required %0d", g, e); else passed++;
        end
`else
        int v0;
        guess_ready = 1'b1;
        press_key(12'h002, 10);
        v0 = vld_cycles;
        press_key(12'h800, 10);
        checks++;
        if (vld_cycles != v0) $display("FAIL hash_ignored valid cycles=%0d required 0", vld_cycles - v0); else passed++;
        checks++;
        if ({key_held, key_num} !== 5'b1_0010) $display("FAIL hash_keeps held/num=%b required 10010", {key_held, key_num}); else passed++;
`endif
    endtask

    initial begin
        test_reset;
        test_digit;
        test_bounce;
        test_multi;
        test_backpressure;
        test_star;
        test_same_cycle;
        test_reset_mid;
        test_hash;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
